sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter and timing sequencer for the 16-bit asynchronous SRAM used as the imager frame buffer. Two synchronous requesters, typically the pixel writer and the readout DMA, issue single-word read/write requests. The block grants one at a time and drives the SRAM chip-enable, write-enable and output-enable strobes and the bidirectional data bus with fixed, parameterised setup/strobe/hold cycles. It sits between the imager datapath and the SRAM pins.

## Interface
- ADDR_WIDTH, 18, SRAM word-address width.
- DATA_WIDTH, 16, SRAM data width.
- WAIT_CYCLES, 1, strobe length in clk cycles (web or oeb low); legal range ≥1.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  2  per-requester request; held high until matching ack bit.
- we  input  2  per-requester 1=write, 0=read; stable while req high.
- addr0, addr1  input  ADDR_WIDTH  per-requester word address.
- wdata0, wdata1  input  DATA_WIDTH  per-requester write data.
- ack  output  2  one-cycle completion pulse per requester.
- rdata  output  DATA_WIDTH  read data; valid in the cycle ack is high for a read.
- sram_ceb  output  1  chip enable, active low.
- sram_web  output  1  write enable, active low.
- sram_oeb  output  1  output enable, active low.
- sram_addr  output  ADDR_WIDTH  SRAM address.
- sram_data  inout  DATA_WIDTH  SRAM data bus; driven only during a write transaction, else high-Z.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: ceb=web=oeb=1, bus Z. If any req is high, pick a winner, latch its we/addr/wdata, and go to SETUP.
- SETUP, 1 cycle: ceb=0, sram_addr=latched addr. Write: bus driven, web=1. Read: oeb=0.
- STROBE, WAIT_CYCLES cycles, via down-counter: write web=0, bus driven; read oeb=0. On the last STROBE cycle, a read registers sram_data into rdata.
- HOLD, 1 cycle: web=1, oeb=1, ceb=0; write keeps the bus driven; ack[granted]=1.
- From HOLD: if the other requester's req is high, grant it and go to SETUP (back-to-back, ceb stays low). Otherwise go to IDLE. The just-acked requester is excluded at this edge.
- Arbitration: round-robin. The pointer flips to the non-winner after each grant. If both requesters are requesting in IDLE, the pointer decides. Reset pointer is requester 0.
- sram_addr, wdata and the write direction come only from latched registers. They never change while web=0.
- Bus never driven while oeb=0 (mutually exclusive by construction).
- rdata holds its last value until the next read completes.

## Timing
- Reset (async, immediate): state=IDLE, ceb=web=oeb=1, sram_addr=0, bus Z, ack=0, rdata=0, pointer=0, counter=0.
- Latency: req sampled high in IDLE at edge N → ack high in cycle N+2+WAIT_CYCLES. Transaction occupancy is WAIT_CYCLES+2 cycles.
- Back-to-back alternating throughput: one word per WAIT_CYCLES+2 cycles.
- Reset asserted mid-write: web returns high at the same instant as ceb. The SRAM word content is undefined; no ack is issued.
- A req that drops before ack is a protocol violation. The transaction still completes, and the ack is still pulsed.

## Configuration
- SRAM_ARBITER_FIXED_PRI_EN defined: fixed priority, requester 0 always wins ties. The HOLD exclusion rule still applies, so requester 1 gets the slot following each requester-0 transaction if it is waiting.
- Undefined (default): round-robin as above.

## Structure
- Package sram_arbiter_pkg: state enum (IDLE, SETUP, STROBE, HOLD) and a localparam for the counter width, $clog2(WAIT_CYCLES+1).
- One sub-module, sram_arbiter_pick: combinational 2-way winner select from req, pointer and exclude mask. The compile-time macro is honoured inside it.

## Test plan
- Single write, WAIT_CYCLES=1: req=2'b01, we0=1, addr0=5, wdata0=16'hA5A5 → web low exactly 1 cycle, bus driven SETUP through HOLD, ack=2'b01 three cycles after the request edge, SRAM model word 5 = A5A5.
- Read-back: req1 read of addr 5 → oeb low 2 cycles, bus Z from the arbiter, ack=2'b10 with rdata=16'hA5A5.
- Contention: both req high from reset with write 0→addr 1, write 1→addr 2 → grant order 0,1,0,1 (round-robin), ceb continuously low, each ack spaced WAIT_CYCLES+2 cycles. Under SRAM_ARBITER_FIXED_PRI_EN the same order also holds.
- WAIT_CYCLES=3 sweep: 100 random read/write pairs against the model → all reads match a scoreboard; web/oeb low pulses exactly 3 cycles; never data-driven while oeb=0 (assertion).
- Reset mid-STROBE of a write → within the same cycle ceb=web=oeb=1 and bus Z; ack stays 0; the next request after reset starts at pointer 0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizing helpers for the two-port SRAM arbiter.
// Optional build macro SRAM_ARBITER_FIXED_PRI_EN is honoured in sram_arbiter_pick.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEFAULT_WAIT_CYCLES = 1;
  localparam int CNT_WIDTH = $clog2(DEFAULT_WAIT_CYCLES + 1);

  // Strobe down-counter width for an arbitrary WAIT_CYCLES (never narrower than 1 bit).
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_pick.sv
// Combinational 2-way winner select: round-robin by default, fixed priority to
// requester 0 when SRAM_ARBITER_FIXED_PRI_EN is defined.
module sram_arbiter_pick
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic [1:0] i_excl,
  output logic       o_valid,
  output logic       o_winner
);

  logic [1:0] w_elig;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign w_elig[gi] = i_req[gi] & ~i_excl[gi];
    end
  endgenerate

  always_comb begin
    o_valid  = |w_elig;
    o_winner = 1'b0;
    if (w_elig == 2'b11) begin
`ifdef SRAM_ARBITER_FIXED_PRI_EN
      o_winner = 1'b0;
`else
      o_winner = i_ptr;
`endif
    end else begin
      o_winner = w_elig[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter and SETUP/STROBE/HOLD timing sequencer for an async SRAM.
// Arbitration policy selected by SRAM_ARBITER_FIXED_PRI_EN (see sram_arbiter_pick).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_req,
  input  logic [1:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic [1:0]            o_ack,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_sram_ceb,
  output logic                  o_sram_web,
  output logic                  o_sram_oeb,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  inout  wire  [DATA_WIDTH-1:0] io_sram_data
);

  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(WAIT_CYCLES - 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_gnt;
  logic                  r_ptr;
  logic                  r_we;
  logic                  r_drive;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_ack;
  logic                  r_ceb;
  logic                  r_web;
  logic                  r_oeb;

  logic [1:0]            w_excl;
  logic                  w_valid;
  logic                  w_winner;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // In HOLD the requester being acked must not win the very next slot.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_excl
      assign w_excl[gi] = (r_state == HOLD) && (r_gnt == 1'(gi));
    end
  endgenerate

  sram_arbiter_pick u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .i_excl   (w_excl),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_sel_we    = w_winner ? i_we[1]  : i_we[0];
  assign w_sel_addr  = w_winner ? i_addr1  : i_addr0;
  assign w_sel_wdata = w_winner ? i_wdata1 : i_wdata0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gnt   <= 1'b0;
      r_ptr   <= 1'b0;
      r_we    <= 1'b0;
      r_drive <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 2'b00;
      r_ceb   <= 1'b1;
      r_web   <= 1'b1;
      r_oeb   <= 1'b1;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        IDLE, HOLD: begin
          if (w_valid) begin
            r_gnt   <= w_winner;
            r_ptr   <= ~w_winner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= SETUP;
            r_ceb   <= 1'b0;
            r_web   <= 1'b1;
            r_oeb   <= w_sel_we;
            r_drive <= w_sel_we;
          end else begin
            r_state <= IDLE;
            r_ceb   <= 1'b1;
            r_web   <= 1'b1;
            r_oeb   <= 1'b1;
            r_drive <= 1'b0;
          end
        end
        SETUP: begin
          r_state <= STROBE;
          r_cnt   <= STROBE_LOAD;
          r_web   <= ~r_we;
          r_oeb   <= r_we;
          r_drive <= r_we;
        end
        STROBE: begin
          if (r_cnt == '0) begin
            r_state <= HOLD;
            r_web   <= 1'b1;
            r_oeb   <= 1'b1;
            r_ack   <= r_gnt ? 2'b10 : 2'b01;
            if (!r_we) begin
              r_rdata <= io_sram_data;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_rdata      = r_rdata;
  assign o_sram_ceb   = r_ceb;
  assign o_sram_web   = r_web;
  assign o_sram_oeb   = r_oeb;
  assign o_sram_addr  = r_addr;
  assign io_sram_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule
